// File: rtl/kb_pkg.sv
// Shared constants, event layout and frame FSM encoding for the PS/2 keyboard receive path.
package kb_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_EE = 8'hEE;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_evt_t;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_e;

  // True for bytes that carry a key code rather than a prefix, ack or error marker.
  function automatic logic is_key_byte(input logic [7:0] b);
    return !(b inside {SC_E0, SC_F0, SC_E1, SC_AA, SC_FA, SC_EE, SC_FE, SC_00, SC_FF});
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, falling-edge sample strobe, 11-bit frame FSM and inactivity timeout.
module ps2_frame_rx
  import kb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       sclr,
  input  logic       ps2_clk_n,
  input  logic       ps2_dat,
  output logic       byte_stb,
  output logic [7:0] byte_data,
  output logic       err_parity,
  output logic       err_timeout
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_d;
  logic                   dat_d;
  logic                   smp_stb;
  frame_state_e           state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   parity_ok;
  logic [TO_W-1:0]        tmo_cnt;

  // Lines idle high, so the chain resets to 1 to avoid a false falling edge after reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_d    <= 1'b1;
      dat_d    <= 1'b1;
      smp_stb  <= 1'b0;
    end else if (sclr) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_d    <= 1'b1;
      dat_d    <= 1'b1;
      smp_stb  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_n};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_d    <= clk_sync[SYNC_STAGES-1];
      dat_d    <= dat_sync[SYNC_STAGES-1];
      smp_stb  <= clk_d & ~clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= FR_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_ok   <= 1'b0;
      tmo_cnt     <= '0;
      byte_stb    <= 1'b0;
      byte_data   <= '0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
    end else if (sclr) begin
      state       <= FR_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_ok   <= 1'b0;
      tmo_cnt     <= '0;
      byte_stb    <= 1'b0;
      byte_data   <= '0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      byte_stb    <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
      if (smp_stb) begin
        tmo_cnt <= '0;
        unique case (state)
          FR_IDLE: begin
            if (!dat_d) begin
              state   <= FR_DATA;
              bit_cnt <= '0;
            end
          end
          FR_DATA: begin
            shreg   <= {dat_d, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= FR_PARITY;
          end
          FR_PARITY: begin
            parity_ok <= ^{shreg, dat_d};
            state     <= FR_STOP;
          end
          FR_STOP: begin
            state <= FR_IDLE;
            if (parity_ok && dat_d) begin
              byte_stb  <= 1'b1;
              byte_data <= shreg;
            end else begin
              err_parity <= 1'b1;
            end
          end
          default: state <= FR_IDLE;
        endcase
      end else if (state != FR_IDLE) begin
        if (tmo_cnt == TO_LAST) begin
          err_timeout <= 1'b1;
          state       <= FR_IDLE;
          tmo_cnt     <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kb_event_rx.sv
// PS/2 keyboard receive path: frame receiver, scan-code set 2 decoder and show-ahead event FIFO.
// Optional typematic repeat suppression is built when KB_TYPEMATIC_FILTER_EN is defined.
module kb_event_rx
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        i_arst_n,
  input  logic                        i_sclr,
  input  logic                        i_ps2_clk_n,
  input  logic                        i_ps2_dat,
  output logic                        o_evt_valid,
  input  logic                        i_evt_ready,
  output logic [7:0]                  o_evt_code,
  output logic                        o_evt_ext,
  output logic                        o_evt_brk,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
  output logic                        o_ovf,
  output logic                        o_err_parity,
  output logic                        o_err_frame,
  output logic [15:0]                 o_last_code
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  logic             byte_stb;
  logic [7:0]       byte_data;
  logic             tmo_err;
  logic             dec_err;
  logic             ext_q;
  logic             brk_q;
  logic [2:0]       e1_left;
  logic             evt_push;
  kb_evt_t          evt_in;
  logic             held_hit;
  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  kb_evt_t          head;
  logic             pop;
  logic             full;
  logic             do_wr;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame (
    .clk         (clk),
    .arst_n      (i_arst_n),
    .sclr        (i_sclr),
    .ps2_clk_n   (i_ps2_clk_n),
    .ps2_dat     (i_ps2_dat),
    .byte_stb    (byte_stb),
    .byte_data   (byte_data),
    .err_parity  (o_err_parity),
    .err_timeout (tmo_err)
  );

`ifdef KB_TYPEMATIC_FILTER_EN
  logic       held_v;
  logic [8:0] held_key;

  assign held_hit = held_v && (held_key == {ext_q, byte_data});

  // A new make becomes the held key; only the break of that same key releases it.
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      held_v   <= 1'b0;
      held_key <= '0;
    end else if (i_sclr) begin
      held_v   <= 1'b0;
      held_key <= '0;
    end else if (byte_stb && (e1_left == 3'd0) && is_key_byte(byte_data)) begin
      if (brk_q) begin
        if (held_hit) held_v <= 1'b0;
      end else begin
        held_v   <= 1'b1;
        held_key <= {ext_q, byte_data};
      end
    end
  end
`else
  assign held_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      e1_left     <= '0;
      evt_push    <= 1'b0;
      evt_in      <= '0;
      dec_err     <= 1'b0;
      o_last_code <= '0;
    end else if (i_sclr) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      e1_left     <= '0;
      evt_push    <= 1'b0;
      evt_in      <= '0;
      dec_err     <= 1'b0;
      o_last_code <= '0;
    end else begin
      evt_push <= 1'b0;
      dec_err  <= 1'b0;
      if (byte_stb) begin
        if (e1_left != 3'd0) begin
          // Pause sequence: swallow its tail and report it as a single E1 make.
          e1_left <= e1_left - 3'd1;
          if (e1_left == 3'd1) begin
            evt_push    <= 1'b1;
            evt_in      <= {2'b00, SC_E1};
            o_last_code <= {8'h00, SC_E1};
          end
        end else if (is_key_byte(byte_data)) begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (brk_q || !held_hit) begin
            evt_push <= 1'b1;
            evt_in   <= {ext_q, brk_q, byte_data};
          end
          if (!brk_q && !held_hit) o_last_code <= {(ext_q ? SC_E0 : 8'h00), byte_data};
        end else begin
          ext_q <= (byte_data == SC_E0) ? 1'b1 : ((byte_data == SC_F0) ? ext_q : 1'b0);
          brk_q <= (byte_data == SC_F0) ? 1'b1 : ((byte_data == SC_E0) ? brk_q : 1'b0);
          if (byte_data == SC_E1) e1_left <= 3'd7;
          if ((byte_data == SC_00) || (byte_data == SC_FF)) dec_err <= 1'b1;
        end
      end
    end
  end

  assign full  = (cnt == DEPTH_C);
  assign pop   = (cnt != '0) && i_evt_ready;
  assign do_wr = evt_push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= evt_in;
  end

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      o_ovf  <= 1'b0;
    end else if (i_sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (evt_push && full && !pop) o_ovf <= 1'b1;
      case ({do_wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head is gated so the event outputs read zero while the FIFO is empty.
  assign head        = kb_evt_t'(mem[rd_ptr]);
  assign o_evt_valid = (cnt != '0);
  assign o_evt_code  = o_evt_valid ? head.code : 8'h00;
  assign o_evt_ext   = o_evt_valid & head.ext;
  assign o_evt_brk   = o_evt_valid & head.brk;
  assign o_fifo_cnt  = cnt;
  assign o_err_frame = tmo_err | dec_err;

endmodule

// File: tb/tb_kb_event_rx.sv
// Self-checking bench for kb_event_rx: directed and random PS/2 frames against a byte-level model.
module tb_kb_event_rx;

  localparam int DEPTH   = 8;
  localparam int TMO     = 200;
  localparam int SYNC    = 2;
  localparam int HALF    = 6;
  localparam int LATENCY = SYNC + 4;

  logic        clk = 1'b0;
  logic        i_arst_n;
  logic        i_sclr;
  logic        i_ps2_clk_n;
  logic        i_ps2_dat;
  logic        o_evt_valid;
  logic        i_evt_ready;
  logic [7:0]  o_evt_code;
  logic        o_evt_ext;
  logic        o_evt_brk;
  logic [3:0]  o_fifo_cnt;
  logic        o_ovf;
  logic        o_err_parity;
  logic        o_err_frame;
  logic [15:0] o_last_code;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int stop_fall_cyc = -100;
  int lat_seen_cyc  = -1;
  bit lat_armed     = 1'b0;
  int obs_par = 0, obs_frm = 0;
  logic [9:0] obs_q[$];

  logic [9:0]  exp_q[$];
  logic        m_ext, m_brk, m_held_v, m_ovf;
  logic [8:0]  m_held;
  logic [15:0] m_last;
  int          m_skip;
  int          exp_par = 0, exp_frm = 0;

  kb_event_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .i_arst_n     (i_arst_n),
    .i_sclr       (i_sclr),
    .i_ps2_clk_n  (i_ps2_clk_n),
    .i_ps2_dat    (i_ps2_dat),
    .o_evt_valid  (o_evt_valid),
    .i_evt_ready  (i_evt_ready),
    .o_evt_code   (o_evt_code),
    .o_evt_ext    (o_evt_ext),
    .o_evt_brk    (o_evt_brk),
    .o_fifo_cnt   (o_fifo_cnt),
    .o_ovf        (o_ovf),
    .o_err_parity (o_err_parity),
    .o_err_frame  (o_err_frame),
    .o_last_code  (o_last_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: record every accepted event and every error pulse.
  always @(negedge clk) begin
    if (i_arst_n) begin
      if (o_evt_valid && i_evt_ready) obs_q.push_back({o_evt_ext, o_evt_brk, o_evt_code});
      if (o_err_parity) obs_par++;
      if (o_err_frame) obs_frm++;
      if (lat_armed && o_evt_valid) begin
        lat_seen_cyc = cyc;
        lat_armed    = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=hang required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives the first nbits bits of an 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop).
  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      i_ps2_dat = bits[i];
      tick(HALF);
      i_ps2_clk_n = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      tick(HALF);
      i_ps2_clk_n = 1'b1;
    end
    i_ps2_dat = 1'b1;
    tick(HALF);
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held_v = 0; m_held = '0; m_ovf = 0; m_last = '0; m_skip = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic model_push(input logic [9:0] e);
    if (!i_evt_ready && exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(e);
  endtask

  // Scan-code set 2 rules applied one received byte at a time.
  task automatic model_byte(input logic [7:0] b);
    logic [8:0] key;
    logic       suppress;
    key      = {m_ext, b};
    suppress = 1'b0;
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin
        model_push({2'b00, 8'hE1});
        m_last = 16'h00E1;
      end
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      exp_frm++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else begin
`ifdef KB_TYPEMATIC_FILTER_EN
      suppress = m_held_v && (m_held == key);
`endif
      if (m_brk) begin
        model_push({m_ext, 1'b1, b});
        if (suppress) m_held_v = 1'b0;
      end else if (!suppress) begin
        model_push({m_ext, 1'b0, b});
        m_last = {(m_ext ? 8'hE0 : 8'h00), b};
`ifdef KB_TYPEMATIC_FILTER_EN
        m_held   = key;
        m_held_v = 1'b1;
`endif
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    applyStimulus(b, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic compareAll(input string tag);
    int n;
    tick(20);
    checkOutput({tag, " evt_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("%s evt%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    checkOutput({tag, " last_code"}, o_last_code, m_last);
    checkOutput({tag, " parity_errs"}, obs_par, exp_par);
    checkOutput({tag, " frame_errs"}, obs_frm, exp_frm);
    checkOutput({tag, " ovf"}, o_ovf, m_ovf);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    i_arst_n = 1'b0; i_sclr = 1'b0; i_ps2_clk_n = 1'b1; i_ps2_dat = 1'b1; i_evt_ready = 1'b0;
    model_reset();
    tick(5);
    i_arst_n = 1'b1;
    tick(3);
    checkOutput("rst valid", o_evt_valid, 0);
    checkOutput("rst cnt", o_fifo_cnt, 0);
    checkOutput("rst ovf", o_ovf, 0);
    checkOutput("rst last_code", o_last_code, 0);
    checkOutput("rst code", o_evt_code, 0);

    i_evt_ready = 1'b1;
    lat_armed = 1'b1;
    send(8'h1C);
    compareAll("make1C");
    checkOutput("valid latency", lat_seen_cyc - stop_fall_cyc, LATENCY);

    send(8'hE0); send(8'hF0); send(8'h74);
    compareAll("ext_brk74");

    applyStimulus(8'h1C, 1'b1, 11);
    exp_par++;
    send(8'h1C);
    compareAll("bad_parity");

    applyStimulus(8'h55, 1'b0, 6);
    tick(TMO + 20);
    exp_frm++;
    send(8'h32);
    compareAll("timeout");

    send(8'h00); send(8'hE0); send(8'hFF); send(8'h2B);
    compareAll("err_bytes");

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hAA); send(8'hE0); send(8'hFA); send(8'h45);
    compareAll("pause_ack");

    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    compareAll("typematic");

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else b = 8'(8'h10 + $urandom_range(0, 3));
      send(b);
    end
    send(8'h29);
    compareAll("random");

    tick(1);
    i_evt_ready = 1'b0;
    b = 8'($urandom_range(1, 8'h60));
    for (int i = 0; i < DEPTH + 1; i++) send(8'(b + i));
    tick(20);
    checkOutput("full cnt", o_fifo_cnt, exp_q.size());
    checkOutput("full ovf", o_ovf, m_ovf);
    i_evt_ready = 1'b1;
    compareAll("overflow_drain");
    i_sclr = 1'b1;
    tick(1);
    i_sclr = 1'b0;
    model_reset();
    tick(2);
    checkOutput("sclr ovf", o_ovf, m_ovf);
    checkOutput("sclr cnt", o_fifo_cnt, 0);
    checkOutput("sclr last_code", o_last_code, m_last);

    send(8'hE0);
    applyStimulus(8'h1C, 1'b0, 4);
    i_arst_n = 1'b0;
    model_reset();
    tick(3);
    checkOutput("arst valid", o_evt_valid, 0);
    i_arst_n = 1'b1;
    tick(3);
    send(8'h1C);
    compareAll("arst_midframe");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
